// File: rtl/led_mode_arbiter_pkg.sv
// Shared mode encodings and default 150 MHz timing constants for the LED mode arbiter.
package led_mode_arbiter_pkg;

  localparam int unsigned DEF_LED_W           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_500_000;
  localparam int unsigned DEF_TICK_DIV        = 15_000_000;
  localparam int unsigned DEF_BUTTON_ACT_LOW  = 1;

  typedef enum logic [1:0] {
    MODE_CPU   = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  // Display modes cycle CPU -> CHASE -> BLINK -> OFF -> CPU on each press.
  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    case (m)
      MODE_CPU:   n = MODE_CHASE;
      MODE_CHASE: n = MODE_BLINK;
      MODE_BLINK: n = MODE_OFF;
      default:    n = MODE_CPU;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_mode_arbiter_button_debounce.sv
// Board button conditioner: 2-flop synchroniser, polarity normalisation,
// stable-level debounce and a one-cycle press pulse on the clean 0->1 edge.
module button_debounce
  import led_mode_arbiter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned BUTTON_ACT_LOW  = DEF_BUTTON_ACT_LOW
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic level,
  output logic press_evt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic RELEASED_RAW = (BUTTON_ACT_LOW != 0);

  logic             sync1;
  logic             sync2;
  logic             pressed_c;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rel_cnt;

  assign pressed_c = sync2 ^ RELEASED_RAW;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RELEASED_RAW;
      sync2 <= RELEASED_RAW;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level     <= 1'b0;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (pressed_c == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level     <= pressed_c;
        cnt       <= '0;
        press_evt <= pressed_c & armed;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // A button held through reset must be seen cleanly released before it can count as a press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed   <= 1'b0;
      rel_cnt <= '0;
    end else if (!armed) begin
      if (pressed_c) begin
        rel_cnt <= '0;
      end else if (rel_cnt == CNT_LAST) begin
        armed   <= 1'b1;
        rel_cnt <= '0;
      end else begin
        rel_cnt <= rel_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_mode_arbiter.sv
// LED bank owner: arbitrates the LEDs between the Nios PIO and a pattern
// sequencer whose mode is stepped by debounced button presses.
module led_mode_arbiter
  import led_mode_arbiter_pkg::*;
#(
  parameter int unsigned LED_W           = DEF_LED_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
  parameter int unsigned BUTTON_ACT_LOW  = DEF_BUTTON_ACT_LOW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             button,
  input  logic [LED_W-1:0] cpu_leds,
  input  logic             cpu_req,
  output logic             button_to_cpu,
  output logic             cpu_grant,
  output logic [1:0]       mode,
  output logic [LED_W-1:0] leds
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  mode_e             mode_q;
  mode_e             mode_d;
  logic              press_evt;
  logic              running_c;
  logic              tick_c;
  logic              grant_c;
  logic [TICK_W-1:0] tick_cnt;
  logic [LED_W-1:0]  pattern;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BUTTON_ACT_LOW  (BUTTON_ACT_LOW)
  ) u_button_debounce (
    .clock     (clock),
    .reset_n   (reset_n),
    .button    (button),
    .level     (button_to_cpu),
    .press_evt (press_evt)
  );

  always_comb begin
    mode_d = mode_q;
    if (press_evt) begin
      mode_d = next_mode(mode_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_CPU;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign mode      = mode_q;
  assign running_c = (mode_q == MODE_CHASE) || (mode_q == MODE_BLINK);
  assign tick_c    = running_c && (tick_cnt == TICK_LAST);
  assign grant_c   = (mode_q == MODE_CPU) || cpu_req;

  // Prescaler ignores cpu_req so the pattern keeps its phase across CPU overrides.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (press_evt || !running_c || tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // A mode change reloads the pattern even when it coincides with a tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pattern <= '0;
    end else if (press_evt) begin
      case (mode_d)
        MODE_CHASE: pattern <= LED_W'(1);
        MODE_BLINK: pattern <= '1;
        default:    pattern <= pattern;
      endcase
    end else if (tick_c && !cpu_req) begin
      case (mode_q)
        MODE_CHASE: pattern <= {pattern[LED_W-2:0], pattern[LED_W-1]};
        MODE_BLINK: pattern <= ~pattern;
        default:    pattern <= pattern;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_grant <= 1'b1;
      leds      <= '0;
    end else begin
      cpu_grant <= grant_c;
      if (grant_c) begin
        leds <= cpu_leds;
      end else if (mode_q == MODE_OFF) begin
        leds <= '0;
      end else begin
        leds <= pattern;
      end
    end
  end

endmodule

// File: tb/tb_led_mode_arbiter.sv
// Scoreboard bench for led_mode_arbiter: a behavioural model predicts each
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_led_mode_arbiter;

  localparam int D = 4;
  localparam int T = 3;

  logic       clock;
  logic       reset_n;
  logic       button;
  logic [3:0] cpu_leds;
  logic       cpu_req;
  logic       button_to_cpu;
  logic       cpu_grant;
  logic [1:0] mode;
  logic [3:0] leds;

  led_mode_arbiter #(
    .LED_W           (4),
    .DEBOUNCE_CYCLES (D),
    .TICK_DIV        (T),
    .BUTTON_ACT_LOW  (1)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .button        (button),
    .cpu_leds      (cpu_leds),
    .cpu_req       (cpu_req),
    .button_to_cpu (button_to_cpu),
    .cpu_grant     (cpu_grant),
    .mode          (mode),
    .leds          (leds)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] leds;
    logic       grant;
    logic [1:0] mode;
    logic       btn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Behavioural model state: pressed-level history, debounce run lengths,
  // mode, edges since the mode was entered, and pattern advances since entry.
  bit pressed_in;
  bit dly[2];
  bit m_db;
  bit m_armed;
  bit m_press;
  int m_run;
  int m_rel;
  int m_mode;
  int m_since;
  int m_adv;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
  endtask

  function automatic logic [3:0] pattern_of(input int md, input int adv);
    if (md == 1) return 4'(1 << (adv % 4));
    if (md == 2) return (adv % 2 == 1) ? 4'h0 : 4'hF;
    return 4'h0;
  endfunction

  task automatic model_reset();
    dly[0] = 1'b0; dly[1] = 1'b0;
    m_db = 1'b0; m_armed = 1'b0; m_press = 1'b0;
    m_run = 0; m_rel = 0; m_mode = 0; m_since = 0; m_adv = 0;
  endtask

  // One clock edge of the reference behaviour; pushes the expected outputs.
  task automatic model_step();
    bit   ps;
    bit   new_press;
    exp_t e;
    ps = dly[0];
    dly[0] = dly[1];
    dly[1] = pressed_in;
    e.grant = (m_mode == 0) || cpu_req;
    e.leds  = e.grant ? cpu_leds : ((m_mode == 3) ? 4'h0 : pattern_of(m_mode, m_adv));
    new_press = 1'b0;
    if (ps != m_db) begin
      m_run++;
      if (m_run == D) begin
        m_db = ps;
        m_run = 0;
        new_press = ps && m_armed;
      end
    end else begin
      m_run = 0;
    end
    if (!m_armed) begin
      if (ps) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel == D) m_armed = 1'b1;
      end
    end
    if (m_press) begin
      m_mode = (m_mode + 1) % 4;
      m_since = 0;
      m_adv = 0;
    end else begin
      m_since++;
      if ((m_mode == 1 || m_mode == 2) && (m_since % T == 0) && !cpu_req) m_adv++;
    end
    m_press = new_press;
    e.mode = 2'(m_mode);
    e.btn  = m_db;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at a falling edge, model the rising edge, return at the next fall.
  task automatic cycle(input bit p, input bit r, input logic [3:0] l);
    pressed_in = p;
    button = p ? 1'b0 : 1'b1;
    cpu_req = r;
    cpu_leds = l;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic press_once(input int hold);
    repeat (hold) cycle(1'b1, 1'b0, 4'h3);
    repeat (8) cycle(1'b0, 1'b0, 4'h3);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("leds", 32'(leds), 32'(e.leds));
        check("cpu_grant", 32'(cpu_grant), 32'(e.grant));
        check("mode", 32'(mode), 32'(e.mode));
        check("button_to_cpu", 32'(button_to_cpu), 32'(e.btn));
      end
    end
  end

  initial begin : stimulus
    reset_n = 1'b0;
    pressed_in = 1'b0;
    button = 1'b1;
    cpu_req = 1'b0;
    cpu_leds = 4'hA;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_grant", 32'(cpu_grant), 32'h1);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_btn", 32'(button_to_cpu), 32'h0);
    reset_n = 1'b1;

    // Reset exit with CPU owning the LEDs, then a bounce and a real press.
    repeat (6) cycle(1'b0, 1'b0, 4'hA);
    repeat (2) cycle(1'b1, 1'b0, 4'hA);
    repeat (2) cycle(1'b0, 1'b0, 4'hA);
    repeat (4) cycle(1'b0, 1'b0, 4'hA);
    check("bounce_mode", 32'(mode), 32'h0);
    check("bounce_btn", 32'(button_to_cpu), 32'h0);
    repeat (10) cycle(1'b1, 1'b0, 4'hA);
    check("press_btn", 32'(button_to_cpu), 32'h1);
    repeat (8) cycle(1'b0, 1'b0, 4'hA);
    check("press_mode", 32'(mode), 32'h1);

    // CHASE free-running, then BLINK with a CPU override in the middle.
    repeat (15) cycle(1'b0, 1'b0, 4'h0);
    press_once(8);
    repeat (9) cycle(1'b0, 1'b0, 4'h0);
    repeat (5) cycle(1'b0, 1'b1, 4'h5);
    repeat (10) cycle(1'b0, 1'b0, 4'h0);

    // Full mode cycle from CPU, first press held long.
    while (m_mode != 0) press_once(8);
    press_once(50);
    press_once(8);
    press_once(8);
    repeat (6) cycle(1'b0, 1'b0, 4'h9);
    press_once(8);
    check("cycle_mode", 32'(mode), 32'h0);

    // Random button activity, CPU requests and LED values.
    for (int i = 0; i < 60; i++) begin
      bit         p;
      bit         r;
      logic [3:0] l;
      int         len;
      p = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) == 0);
      l = 4'($urandom);
      len = $urandom_range(1, 12);
      repeat (len) cycle(p, r, l);
    end
    repeat (12) cycle(1'b0, 1'b0, 4'h0);

    // Reset in CHASE while the button is held; no press may follow.
    while (m_mode != 0) press_once(8);
    repeat (15) cycle(1'b1, 1'b0, 4'h6);
    check("pre_rst_btn", 32'(button_to_cpu), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_leds", 32'(leds), 32'h0);
    check("async_rst_grant", 32'(cpu_grant), 32'h1);
    check("async_rst_mode", 32'(mode), 32'h0);
    check("async_rst_btn", 32'(button_to_cpu), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    repeat (20) cycle(1'b1, 1'b0, 4'h6);
    check("held_rst_mode", 32'(mode), 32'h0);
    check("held_rst_btn", 32'(button_to_cpu), 32'h1);
    repeat (10) cycle(1'b0, 1'b0, 4'h6);
    press_once(8);
    check("post_rst_press", 32'(mode), 32'h1);

    @(posedge clock);
    #2;
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
